// File: rtl/main_memory_responder.sv
// main_memory_responder
//
// Fixed-latency main-memory model that answers single-word read/write
// requests from the L3 cache. A request is accepted in IDLE and then runs
// for MEM_LATENCY BUSY cycles. A one-cycle DONE strobe follows, after which
// the responder returns to IDLE.
//
// Parameter defaults follow the system main_memory_config:
//   MAIN_MEMORY_ADDRESS_WIDTH = 32 (word address), MAIN_MEMORY_DATA_WIDTH = 64
//   (cache line). MEM_DEPTH must be a power of two >= 2. MEM_LATENCY must be >= 1.
//
// Optional feature: define MAIN_MEMORY_PARITY_EN to store one even-parity bit
// per word and check it on read completion.
//
// Ports:
//   clk                              clock, rising edge
//   reset                            asynchronous, active-high reset
//   main_memory_read_request         read request
//   main_memory_write_request        write request (wins over a simultaneous read)
//   main_memory_address              word address (wraps modulo MEM_DEPTH)
//   main_memory_write_data           write word
//   main_memory_inject_parity_fault  invert stored parity on this write
//   main_memory_ready                high only in IDLE
//   main_memory_done                 one-cycle completion strobe
//   main_memory_read_data            last read word, held until next read completes
//   main_memory_parity_error         parity mismatch, pulses with done on reads
module main_memory_responder #(
  parameter int MAIN_MEMORY_ADDRESS_WIDTH = 32,
  parameter int MAIN_MEMORY_DATA_WIDTH    = 64,
  parameter int MEM_DEPTH                 = 256,
  parameter int MEM_LATENCY               = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 main_memory_read_request,
  input  logic                                 main_memory_write_request,
  input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] main_memory_address,
  input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_write_data,
  input  logic                                 main_memory_inject_parity_fault,
  output logic                                 main_memory_ready,
  output logic                                 main_memory_done,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_read_data,
  output logic                                 main_memory_parity_error
);
  localparam int DW    = MAIN_MEMORY_DATA_WIDTH;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  // Counter holds values up to MEM_LATENCY without wrapping.
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  // Loaded with LATENCY-1 so that the transition to DONE happens on the
  // MEM_LATENCY-th edge after accept.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_write_q;
  logic             ready_q;
  logic             done_q;
  logic [DW-1:0]    rdata_q;
  logic [IDX_W-1:0] idx_q;
  logic [DW-1:0]    wdata_q;

  logic             accept;
  logic             finish;
  logic             commit_wr;
  logic [DW-1:0]    word_rd [MEM_DEPTH];
  // Upper address bits are ignored by design. In the default build, the inject input is ignored too.
  logic             unused_inputs;

  assign unused_inputs = ^{main_memory_address, main_memory_inject_parity_fault};

  assign accept    = (state_q == IDLE) &&
                     (main_memory_read_request || main_memory_write_request);
  assign finish    = (state_q == BUSY) && (cnt_q == '0);
  assign commit_wr = finish && is_write_q;

  // Request operands are only sampled at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= main_memory_address[IDX_W-1:0];
      wdata_q <= main_memory_write_data;
    end
  end

  // One register per word, so every word can be cleared by reset.
  for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_word
    logic [DW-1:0] word_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= '0;
      end else if (commit_wr && (idx_q == IDX_W'(g))) begin
        word_q <= wdata_q;
      end
    end
    assign word_rd[g] = word_q;
  end

`ifdef MAIN_MEMORY_PARITY_EN
  logic             inj_q;
  logic             perr_q;
  logic             par_rd [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (accept) begin
      inj_q <= main_memory_inject_parity_fault;
    end
  end

  // Even parity: the stored bit makes the total number of ones even.
  for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_par
    logic par_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        par_q <= 1'b0;
      end else if (commit_wr && (idx_q == IDX_W'(g))) begin
        par_q <= (^wdata_q) ^ inj_q;
      end
    end
    assign par_rd[g] = par_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= finish && !is_write_q && ((^word_rd[idx_q]) != par_rd[idx_q]);
    end
  end

  assign main_memory_parity_error = perr_q;
`else
  assign main_memory_parity_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= BUSY;
            cnt_q      <= CNT_LOAD;
            // A simultaneous read is dropped; the requester re-issues it.
            is_write_q <= main_memory_write_request;
            ready_q    <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (!is_write_q) begin
              rdata_q <= word_rd[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign main_memory_ready     = ready_q;
  assign main_memory_done      = done_q;
  assign main_memory_read_data = rdata_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Testbench for main_memory_responder (default parameters, MEM_LATENCY = 4).
// The testbench drives a table of directed transactions with hand-computed expected results.
// A hand-written sequence then checks reset behavior in the middle of an access.
module tb_main_memory_responder;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int LAT = 4;
  localparam int NV  = 14;
`ifdef MAIN_MEMORY_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          inj;
  logic          rdy;
  logic          done;
  logic [DW-1:0] rdata;
  logic          perr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          inj;
    logic          tog;
    logic [DW-1:0] exp_rd;
    logic          exp_pe;
  } vec_t;

  vec_t vecs [NV];

  main_memory_responder dut (
    .clk                             (clk),
    .reset                           (reset),
    .main_memory_read_request        (rd),
    .main_memory_write_request       (wr),
    .main_memory_address             (addr),
    .main_memory_write_data          (wdata),
    .main_memory_inject_parity_fault (inj),
    .main_memory_ready               (rdy),
    .main_memory_done                (done),
    .main_memory_read_data           (rdata),
    .main_memory_parity_error        (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE and follow it to completion.
  task automatic run_op(input int id, input vec_t v, input logic [DW-1:0] prev);
    int   k;
    int   rlow;
    logic held;
    chk($sformatf("v%0d ready_before", id), 64'(rdy), 64'd1);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata; inj = v.inj;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after accept; the DUT must not sample them again.
    rd = 1'b0; wr = 1'b0; addr = ~v.addr; wdata = ~v.wdata; inj = ~v.inj;
    k = 0; rlow = 0; held = 1'b1;
    while (done !== 1'b1 && k < 20) begin
      if (rdy === 1'b0) rlow++;
      if (rdata !== prev) held = 1'b0;
      if (v.tog) begin
        rd    = 1'($urandom_range(0, 1));
        wr    = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = {$urandom, $urandom};
      end
      @(negedge clk);
      k++;
    end
    rd = 1'b0; wr = 1'b0;
    if (rdy === 1'b0) rlow++;
    chk($sformatf("v%0d done_latency", id), 64'(k), 64'(LAT));
    chk($sformatf("v%0d rdata_held_busy", id), 64'(held), 64'd1);
    chk($sformatf("v%0d rdata_at_done", id), rdata, v.exp_rd);
    chk($sformatf("v%0d parity_at_done", id), 64'(perr), 64'(v.exp_pe));
    @(negedge clk);
    chk($sformatf("v%0d done_cleared", id), 64'(done), 64'd0);
    chk($sformatf("v%0d ready_back", id), 64'(rdy), 64'd1);
    chk($sformatf("v%0d parity_cleared", id), 64'(perr), 64'd0);
    chk($sformatf("v%0d ready_low_cycles", id), 64'(rlow), 64'(LAT + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] prev;
    vec_t          rv;
    int            dcount;

    //            rd    wr    addr        wdata                   inj   tog   exp_rd                  exp_pe
    vecs[0]  = '{1'b1, 1'b0, 32'h005, 64'h0,                  1'b0, 1'b0, 64'h0,                  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h010, 64'hA5A5,               1'b0, 1'b0, 64'h0,                  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h010, 64'h0,                  1'b0, 1'b0, 64'hA5A5,               1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h020, 64'h1234,               1'b0, 1'b0, 64'hA5A5,               1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h020, 64'h0,                  1'b0, 1'b0, 64'h1234,               1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h105, 64'h77,                 1'b0, 1'b1, 64'h1234,               1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h005, 64'h0,                  1'b0, 1'b1, 64'h77,                 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0FF, 64'hDEADBEEF_CAFEF00D,  1'b0, 1'b0, 64'h77,                 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h3FF, 64'h0,                  1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D,  1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h040, 64'h3,                  1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D,  1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h040, 64'h0,                  1'b0, 1'b0, 64'h3,                  PAR_EN};
    vecs[11] = '{1'b0, 1'b1, 32'h041, 64'h3,                  1'b0, 1'b0, 64'h3,                  1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h041, 64'h0,                  1'b0, 1'b0, 64'h3,                  1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h040, 64'h0,                  1'b1, 1'b0, 64'h3,                  PAR_EN};

    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; inj = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(rdy), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset rdata", rdata, 64'd0);
    chk("reset parity", 64'(perr), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset ready", 64'(rdy), 64'd1);

    prev = '0;
    for (int i = 0; i < NV; i++) begin
      run_op(i, vecs[i], prev);
      prev = vecs[i].exp_rd;
    end

    // Reset two cycles into a write: access aborted, array and outputs cleared.
    wr = 1'b1; addr = 32'h030; wdata = 64'hFFFF;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset ready", 64'(rdy), 64'd1);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset rdata", rdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("midreset no_done", 64'(dcount), 64'd0);

    rv = '{1'b1, 1'b0, 32'h030, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    run_op(100, rv, 64'h0);
    rv = '{1'b1, 1'b0, 32'h010, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    run_op(101, rv, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
